bcd_score_display: RTL and testbench

Parametrised score keeper and multiplexed seven-segment driver for the game top level. It replaces the hard-wired score bits feeding the display with a saturating BCD score register that accepts point increments from game logic. It also scans NUM_DIGITS common-anode digits at a configurable refresh rate. It sits between the debounced game control logic and the board's `seg`/`an` pins.

---
 rtl/score_pkg.sv | 23 ++
 rtl/seg7_decoder.sv | 27 ++
 rtl/bcd_score_display.sv | 121 ++++++++++++
 tb/tb_bcd_score_display.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants for the BCD score display: digit width, add clamp and active-low {g,f,e,d,c,b,a} glyphs.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] CLAMP_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > CLAMP_MAX) ? CLAMP_MAX : v;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment glyph.
// Zero latency, no flow control; non-BCD codes show blank.
module seg7_decoder
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_score_display.sv
// Saturating BCD score register plus multiplexed common-anode display scan; adds visible next cycle, display one cycle behind.
// No backpressure: every add_en is accepted. Define SCORE_BLANK_LEADING_EN to blank leading zero digits.
module bcd_score_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        add_en,
  input  logic [3:0]                  add_val,
  input  logic                        clear,
  output logic [BCD_W*NUM_DIGITS-1:0] score_bcd,
  output logic                        saturated,
  output logic [6:0]                  seg,
  output logic [NUM_DIGITS-1:0]       an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BCD_W*NUM_DIGITS-1:0] sum_bcd;
  logic                        carry_out;
  logic [PW-1:0]               presc;
  logic [DW-1:0]               d;
  logic [3:0]                  sel_nib;
  logic                        sel_blank;
  logic [6:0]                  dec_seg;

  // Ripple decimal add: clamped value enters digit 0, carry walks upward.
  always_comb begin
    logic       carry;
    logic [4:0] dsum;
    logic [4:0] dadj;
    sum_bcd = score_bcd;
    carry   = 1'b0;
    dsum    = '0;
    dadj    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == 0)
        dsum = {1'b0, score_bcd[i*BCD_W +: BCD_W]} + {1'b0, clamp_digit(add_val)};
      else
        dsum = {1'b0, score_bcd[i*BCD_W +: BCD_W]} + {4'b0000, carry};
      dadj = dsum - 5'd10;
      if (dsum > 5'd9) begin
        sum_bcd[i*BCD_W +: BCD_W] = dadj[3:0];
        carry = 1'b1;
      end else begin
        sum_bcd[i*BCD_W +: BCD_W] = dsum[3:0];
        carry = 1'b0;
      end
    end
    carry_out = carry;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score_bcd <= '0;
      saturated <= 1'b0;
    end else if (add_en) begin
      if (carry_out) begin
        score_bcd <= {NUM_DIGITS{4'h9}};
        saturated <= 1'b1;
      end else begin
        score_bcd <= sum_bcd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      d     <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      d     <= (d == DW'(NUM_DIGITS - 1)) ? '0 : d + DW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    sel_nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (d == DW'(i)) sel_nib = score_bcd[i*BCD_W +: BCD_W];
  end

`ifdef SCORE_BLANK_LEADING_EN
  // A digit is blank when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic hi_zero;
    hi_zero   = 1'b1;
    sel_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero & (score_bcd[i*BCD_W +: BCD_W] == 4'd0);
      if (d == DW'(i)) sel_blank = hi_zero;
    end
  end
`else
  assign sel_blank = 1'b0;
`endif

  seg7_decoder u_dec (
    .bcd (sel_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= sel_blank ? SEG_BLANK : dec_seg;
      an  <= ~(NUM_DIGITS'(1) << d);
    end
  end

  a_sel_is_bcd : assert property (@(posedge clk) disable iff (reset) sel_nib <= 4'd9);

endmodule

// File: tb/tb_bcd_score_display.sv
// Randomised self-checking bench for bcd_score_display against a decimal-integer reference model.
module tb_bcd_score_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int MAXS = 9999;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          add_en = 1'b0;
  logic [3:0]    add_val = '0;
  logic          clear = 1'b0;
  logic [4*ND-1:0] score_bcd;
  logic          saturated;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: score as a plain integer, scan position from cycle count.
  int cyc = 0;
  int m_score = 0;
  bit m_sat = 1'b0;
  logic [4*ND-1:0] exp_score;
  logic            exp_sat;
  logic [ND-1:0]   exp_an;
  logic [6:0]      exp_seg;

  bcd_score_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .add_en(add_en), .add_val(add_val), .clear(clear),
    .score_bcd(score_bcd), .saturated(saturated), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int s);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'((s / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Drive one cycle; expected display comes from the score held before this edge.
  task automatic step(input logic en, input logic [3:0] val, input logic clr);
    int di, v;
    di = (cyc / SD) % ND;
    exp_an  = ~(ND'(1) << di);
    exp_seg = glyph((m_score / p10(di)) % 10);
`ifdef SCORE_BLANK_LEADING_EN
    if (di > 0 && m_score < p10(di)) exp_seg = 7'b1111111;
`endif
    add_en = en; add_val = val; clear = clr;
    if (clr) begin
      m_score = 0; m_sat = 1'b0;
    end else if (en) begin
      v = (val > 9) ? 9 : int'(val);
      if (m_score + v > MAXS) begin
        m_score = MAXS; m_sat = 1'b1;
      end else begin
        m_score = m_score + v;
      end
    end
    exp_score = to_bcd(m_score);
    exp_sat   = m_sat;
    @(posedge clk); #1;
    cyc++;
    add_en = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL reset_an got %b want 1111", an); end
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %b want 1111111", seg); end
    n_cmp++; if (score_bcd !== '0) begin n_bad++; $display("FAIL reset_score got %h want 0", score_bcd); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", saturated); end
    reset = 1'b0;
    cyc = 0; m_score = 0; m_sat = 1'b0;
  endtask

  task automatic test_scan;
    for (int i = 0; i < 2 * ND * SD + 1; i++) begin
      step(1'b0, 4'd0, 1'b0);
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL scan_an cyc=%0d got %b want %b", cyc, an, exp_an); end
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL scan_seg cyc=%0d got %b want %b", cyc, seg, exp_seg); end
    end
  endtask

  task automatic test_add_pair;
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    n_cmp++; if (score_bcd !== 16'h0012) begin n_bad++; $display("FAIL add_pair got %h want 0012", score_bcd); end
    n_cmp++; if (exp_score !== 16'h0012) begin n_bad++; $display("FAIL add_pair_model got %h want 0012", exp_score); end
    for (int i = 0; i < ND * SD + 1; i++) begin
      step(1'b0, 4'd0, 1'b0);
      n_cmp++; if (seg !== exp_seg || an !== exp_an) begin
        n_bad++; $display("FAIL add_pair_disp cyc=%0d got %b/%b want %b/%b", cyc, seg, an, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_clamp;
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd15, 1'b0);
    n_cmp++; if (score_bcd !== 16'h0009) begin n_bad++; $display("FAIL clamp got %h want 0009", score_bcd); end
  endtask

  task automatic test_saturate;
    step(1'b0, 4'd0, 1'b1);
    while (m_score + 9 <= 9995) step(1'b1, 4'd9, 1'b0);
    if (m_score < 9995) step(1'b1, 4'(9995 - m_score), 1'b0);
    n_cmp++; if (score_bcd !== 16'h9995) begin n_bad++; $display("FAIL sat_pre got %h want 9995", score_bcd); end
    step(1'b1, 4'd7, 1'b0);
    n_cmp++; if (score_bcd !== 16'h9999 || saturated !== 1'b1) begin
      n_bad++; $display("FAIL sat_hit got %h/%b want 9999/1", score_bcd, saturated);
    end
    step(1'b1, 4'd1, 1'b0);
    n_cmp++; if (score_bcd !== 16'h9999 || saturated !== 1'b1) begin
      n_bad++; $display("FAIL sat_hold got %h/%b want 9999/1", score_bcd, saturated);
    end
    step(1'b1, 4'd0, 1'b0);
    n_cmp++; if (score_bcd !== 16'h9999 || saturated !== 1'b1) begin
      n_bad++; $display("FAIL sat_add0 got %h/%b want 9999/1", score_bcd, saturated);
    end
  endtask

  task automatic test_clear_add;
    step(1'b1, 4'd3, 1'b1);
    n_cmp++; if (score_bcd !== 16'h0000 || saturated !== 1'b0) begin
      n_bad++; $display("FAIL clear_add got %h/%b want 0000/0", score_bcd, saturated);
    end
    step(1'b1, 4'd3, 1'b0);
    n_cmp++; if (score_bcd !== 16'h0003) begin n_bad++; $display("FAIL clear_then_add got %h want 0003", score_bcd); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 39) == 0));
      n_cmp++; if (score_bcd !== exp_score || saturated !== exp_sat) begin
        n_bad++; $display("FAIL rand_score cyc=%0d got %h/%b want %h/%b", cyc, score_bcd, saturated, exp_score, exp_sat);
      end
      n_cmp++; if (seg !== exp_seg || an !== exp_an) begin
        n_bad++; $display("FAIL rand_disp cyc=%0d got %b/%b want %b/%b", cyc, seg, an, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 4'd8, 1'b0);
    for (int i = 0; i < ND * SD && ((cyc / SD) % ND) != 2; i++) step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    n_cmp++; if (an !== 4'b1011) begin n_bad++; $display("FAIL mid_pre_an got %b want 1011", an); end
    test_reset;
    step(1'b0, 4'd0, 1'b0);
    n_cmp++; if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_bad++; $display("FAIL mid_resume got %b/%b want 1110/1000000", an, seg);
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_add_pair;
    test_clamp;
    test_saturate;
    test_clear_add;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
